acc_cpu: RTL and testbench

Parametrised accumulator CPU: the next-generation core after the 3-bit machine, generalised to DATA_W-bit data and 2^ADDR_W-entry instruction and data memories. It runs a two-phase fetch/execute FSM with start/halt control, carry and zero flags, a conditional branch, and memory-operand arithmetic. The instruction memory is loaded through a write port rather than a file, so the block sits directly under a testbench or loader and exposes the accumulator as its result.

---
 rtl/acc_cpu.sv | 193 +++++++++++++++++++
 tb/tb_acc_cpu.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/acc_cpu.sv
// acc_cpu: parametrised accumulator CPU with a two-phase fetch/execute FSM.
// Optional build macro ACC_CPU_SAT_EN makes ADDI/ADD/SUBI saturate instead of wrapping.
//
// state | meaning
// IDLE  | after reset, waiting for start; imem writable
// FETCH | ir <= imem[pc]
// EXEC  | execute ir, update acc/flags/pc/dmem
// HALT  | program stopped on a HALT instruction; imem writable
module acc_cpu #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                imem_we,
  input  logic [ADDR_W-1:0]   imem_waddr,
  input  logic [ADDR_W+2:0]   imem_wdata,
  output logic [DATA_W-1:0]   acc_out,
  output logic [ADDR_W-1:0]   pc_out,
  output logic                busy,
  output logic                halted,
  output logic                carry,
  output logic                zero
);

  localparam int IW    = ADDR_W + 3;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [2:0] OP_LDI  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_SUBI = 3'b010;
  localparam logic [2:0] OP_LD   = 3'b011;
  localparam logic [2:0] OP_ST   = 3'b100;
  localparam logic [2:0] OP_ADD  = 3'b101;
  localparam logic [2:0] OP_JNZ  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic                carry_q, carry_d;
  logic                zero_q, zero_d;
  logic [IW-1:0]       ir_q, ir_d;
  logic                busy_q, busy_d;
  logic                halted_q, halted_d;

  logic [IW-1:0]       imem [DEPTH];
  logic [DATA_W-1:0]   dmem [DEPTH];

  logic [2:0]          opcode;
  logic [ADDR_W-1:0]   operand;
  logic [DATA_W-1:0]   imm;
  logic [DATA_W-1:0]   mem_rd;
  logic [DATA_W:0]     sum_imm, sum_mem, diff_imm;
  logic [DATA_W-1:0]   addi_res, add_res, subi_res;
  logic                dmem_we;
  logic                imem_wr_ok;

  assign opcode   = ir_q[IW-1 -: 3];
  assign operand  = ir_q[ADDR_W-1:0];
  assign imm      = DATA_W'(operand);
  assign mem_rd   = dmem[operand];

  assign sum_imm  = {1'b0, acc_q} + {1'b0, imm};
  assign sum_mem  = {1'b0, acc_q} + {1'b0, mem_rd};
  assign diff_imm = {1'b0, acc_q} - {1'b0, imm};

`ifdef ACC_CPU_SAT_EN
  // Clamp on overflow; the flag still reports that the true result did not fit.
  assign addi_res = sum_imm[DATA_W]  ? {DATA_W{1'b1}} : sum_imm[DATA_W-1:0];
  assign add_res  = sum_mem[DATA_W]  ? {DATA_W{1'b1}} : sum_mem[DATA_W-1:0];
  assign subi_res = diff_imm[DATA_W] ? {DATA_W{1'b0}} : diff_imm[DATA_W-1:0];
`else
  assign addi_res = sum_imm[DATA_W-1:0];
  assign add_res  = sum_mem[DATA_W-1:0];
  assign subi_res = diff_imm[DATA_W-1:0];
`endif

  assign imem_wr_ok = imem_we && ((state_q == S_IDLE) || (state_q == S_HALT));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    ir_d    = ir_q;
    dmem_we = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          acc_d   = '0;
          carry_d = 1'b0;
          zero_d  = 1'b0;
        end
      end
      S_FETCH: begin
        ir_d    = imem[pc_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_q + ADDR_W'(1);
        case (opcode)
          OP_LDI: begin
            acc_d  = imm;
            zero_d = (imm == '0);
          end
          OP_ADDI: begin
            acc_d   = addi_res;
            carry_d = sum_imm[DATA_W];
            zero_d  = (addi_res == '0);
          end
          OP_SUBI: begin
            acc_d   = subi_res;
            carry_d = diff_imm[DATA_W];
            zero_d  = (subi_res == '0);
          end
          OP_LD: begin
            acc_d  = mem_rd;
            zero_d = (mem_rd == '0);
          end
          OP_ST: begin
            dmem_we = 1'b1;
          end
          OP_ADD: begin
            acc_d   = add_res;
            carry_d = sum_mem[DATA_W];
            zero_d  = (add_res == '0);
          end
          OP_JNZ: begin
            if (!zero_q) pc_d = operand;
          end
          OP_HALT: begin
            state_d = S_HALT;
            pc_d    = pc_q;
          end
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
    busy_d   = (state_d == S_FETCH) || (state_d == S_EXEC);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ir_q     <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      ir_q     <= ir_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  // Memories keep their contents across reset; an ST aborted by reset never reaches here
  // because state_q leaves EXEC asynchronously.
  always_ff @(posedge clk) begin
    if (imem_wr_ok) imem[imem_waddr] <= imem_wdata;
    if (dmem_we)    dmem[operand]    <= acc_q;
  end

  assign acc_out = acc_q;
  assign pc_out  = pc_q;
  assign busy    = busy_q;
  assign halted  = halted_q;
  assign carry   = carry_q;
  assign zero    = zero_q;

endmodule

// File: tb/tb_acc_cpu.sv
// Directed self-checking bench for acc_cpu (DATA_W=8, ADDR_W=4).
module tb_acc_cpu;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       imem_we;
  logic [3:0] imem_waddr;
  logic [6:0] imem_wdata;
  logic [7:0] acc_out;
  logic [3:0] pc_out;
  logic       busy, halted, carry, zero;

  int checks   = 0;
  int failures = 0;
  int cyc;

  acc_cpu #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .acc_out    (acc_out),
    .pc_out     (pc_out),
    .busy       (busy),
    .halted     (halted),
    .carry      (carry),
    .zero       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] ins(input logic [2:0] op, input logic [3:0] opnd);
    return {op, opnd};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [6:0] w);
    imem_we    = 1'b1;
    imem_waddr = a;
    imem_wdata = w;
    @(posedge clk); #1;
    imem_we    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts cycles until busy drops; bounded so a stuck DUT still reaches the summary.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    #2;
    chk("rst_acc", acc_out, 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_carry", carry, 0);
    chk("rst_zero", zero, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // {LDI 5, ADDI 3, HALT}
    wr(0, ins(3'b000, 4'd5));
    wr(1, ins(3'b001, 4'd3));
    wr(2, ins(3'b111, 4'd0));
    pulse_start();
    chk("p1_busy_after_start", busy, 1);
    wait_idle(cyc);
    chk("p1_busy_cycles", cyc, 6);
    chk("p1_halted", halted, 1);
    chk("p1_acc", acc_out, 8);
    chk("p1_pc", pc_out, 2);
    chk("p1_carry", carry, 0);
    chk("p1_zero", zero, 0);

    // {LDI 0, SUBI 1, HALT}, loaded while halted
    wr(0, ins(3'b000, 4'd0));
    wr(1, ins(3'b010, 4'd1));
    pulse_start();
    wait_idle(cyc);
    chk("p2_halted", halted, 1);
`ifdef ACC_CPU_SAT_EN
    chk("p2_acc", acc_out, 8'h00);
    chk("p2_zero", zero, 1);
`else
    chk("p2_acc", acc_out, 8'hFF);
    chk("p2_zero", zero, 0);
`endif
    chk("p2_carry", carry, 1);

    // {LDI 9, ST 3, LDI 0, LD 3, HALT}
    wr(0, ins(3'b000, 4'd9));
    wr(1, ins(3'b100, 4'd3));
    wr(2, ins(3'b000, 4'd0));
    wr(3, ins(3'b011, 4'd3));
    wr(4, ins(3'b111, 4'd0));
    pulse_start();
    wait_idle(cyc);
    chk("p3_acc", acc_out, 9);
    chk("p3_zero", zero, 0);
    chk("p3_pc", pc_out, 4);

    // {LDI 9, ST 3, ADD 3, HALT}
    wr(2, ins(3'b101, 4'd3));
    wr(3, ins(3'b111, 4'd0));
    pulse_start();
    wait_idle(cyc);
    chk("p4_acc", acc_out, 18);
    chk("p4_carry", carry, 0);

    // Countdown {LDI 3, SUBI 1, JNZ 1, HALT}
    wr(0, ins(3'b000, 4'd3));
    wr(1, ins(3'b010, 4'd1));
    wr(2, ins(3'b110, 4'd1));
    wr(3, ins(3'b111, 4'd0));
    pulse_start();
    wait_idle(cyc);
    chk("cd_cycles", cyc, 16);
    chk("cd_halted", halted, 1);
    chk("cd_acc", acc_out, 0);
    chk("cd_zero", zero, 1);
    chk("cd_pc", pc_out, 3);

    // dmem[5]=9 via {LDI 9, ST 5, HALT}
    wr(0, ins(3'b000, 4'd9));
    wr(1, ins(3'b100, 4'd5));
    wr(2, ins(3'b111, 4'd0));
    pulse_start();
    wait_idle(cyc);
    chk("pa_acc", acc_out, 9);

    // {LD 5, ADDI 1, ST 5, HALT}; reset lands in the EXEC of ST
    wr(0, ins(3'b011, 4'd5));
    wr(1, ins(3'b001, 4'd1));
    wr(2, ins(3'b100, 4'd5));
    wr(3, ins(3'b111, 4'd0));
    pulse_start();
    repeat (5) @(posedge clk);
    #1;
    chk("ab_busy_in_st", busy, 1);
    chk("ab_acc_in_st", acc_out, 10);
    rst_n = 1'b0;
    #1;
    chk("ab_rst_acc", acc_out, 0);
    chk("ab_rst_pc", pc_out, 0);
    chk("ab_rst_busy", busy, 0);
    chk("ab_rst_halted", halted, 0);
    chk("ab_rst_flags", {carry, zero}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pulse_start();
    wait_idle(cyc);
    chk("ab_rerun_acc", acc_out, 10);
    chk("ab_rerun_pc", pc_out, 3);
    chk("ab_rerun_halted", halted, 1);

    // {LDI 1, ADDI 2, HALT}; imem write while busy must be ignored
    wr(0, ins(3'b000, 4'd1));
    wr(1, ins(3'b001, 4'd2));
    wr(2, ins(3'b111, 4'd0));
    pulse_start();
    wr(1, ins(3'b001, 4'd5));
    wait_idle(cyc);
    chk("bw_acc", acc_out, 3);
    wr(1, ins(3'b001, 4'd5));
    pulse_start();
    wait_idle(cyc);
    chk("hw_acc", acc_out, 6);
    chk("hw_halted", halted, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
